// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule: SHA-256 message schedule; loads 16 words, then streams W[0..63] one per w_next.
// Optional: define SHA256_MSG_SCHED_ERR_EN to add the sticky protocol-error output err.
module sha256_msg_schedule (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clear,
    input  logic        word_valid,
    input  logic [31:0] word_in,
    output logic        word_ready,
    input  logic        w_next,
    output logic [31:0] w_out,
    output logic        w_valid,
    output logic [5:0]  w_index,
`ifdef SHA256_MSG_SCHED_ERR_EN
    output logic        err,
`endif
    output logic        block_done
);
    typedef enum logic [1:0] {IDLE, LOAD, EXPAND} state_t;

    state_t      state, state_nx;
    logic [5:0]  cnt;
    logic [31:0] win [16];
    logic        xfer, step, last;
    logic [31:0] w_new;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    assign xfer       = word_valid && word_ready;
    assign step       = w_next && state == EXPAND;
    assign last       = cnt == 6'd63;
    assign word_ready = state != EXPAND;
    assign w_valid    = state == EXPAND;
    assign w_out      = win[0];
    assign w_index    = cnt;
    // win[0] holds W[t], so win[k] is W[t+k]
    assign w_new      = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        if (clear) state_nx = IDLE;
        else if (xfer) state_nx = (cnt == 6'd15) ? EXPAND : LOAD;
        else if (step && last) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt        <= '0;
            win        <= '{default: '0};
            block_done <= 1'b0;
        end else if (clear) begin
            cnt        <= '0;
            win        <= '{default: '0};
            block_done <= 1'b0;
        end else begin
            block_done <= step && last;
            if (xfer) begin
                win[cnt[3:0]] <= word_in;
                cnt           <= (cnt == 6'd15) ? 6'd0 : cnt + 6'd1;
            end else if (step) begin
                for (int i = 0; i < 15; i++) win[i] <= win[i+1];
                win[15] <= w_new;
                cnt     <= last ? 6'd0 : cnt + 6'd1;
            end
        end
    end

`ifdef SHA256_MSG_SCHED_ERR_EN
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) err <= 1'b0;
        else if (clear) err <= 1'b0;
        else if ((w_next && !w_valid) || (word_valid && state == EXPAND)) err <= 1'b1;
`endif
endmodule
